// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Drives every pipeline-register write enable, bubble and flush. It resolves
// load-use hazards, taken-branch flushes, multi-cycle EX ops and cache freezes.
//
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   IdExMemRead         EX instruction is a load
//   IdExRegRt           load destination register in EX
//   IfIdRegRs/IfIdRegRt source registers of the ID instruction
//   IfIdUsesRt          ID instruction reads rt
//   BranchTaken         ID branch resolved taken
//   IdExMultiCycle      EX instruction is a multi-cycle op
//   ICacheStall/DCacheStall  cache miss pending (freeze)
//   PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite  write enables
//   IfIdFlush, IdExBubble, ExMemBubble                    nop insertion
//   McStart, McBusy     multi-cycle unit start pulse / busy flag
//   StallCycles, FlushCount  performance counters (zero unless macro set)
module hazard_stall_ctrl #(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IdExMemRead,
   input  logic [REG_W-1:0] IdExRegRt,
   input  logic [REG_W-1:0] IfIdRegRs,
   input  logic [REG_W-1:0] IfIdRegRt,
   input  logic             IfIdUsesRt,
   input  logic             BranchTaken,
   input  logic             IdExMultiCycle,
   input  logic             ICacheStall,
   input  logic             DCacheStall,
   output logic             PcWrite,
   output logic             IfIdWrite,
   output logic             IfIdFlush,
   output logic             IdExWrite,
   output logic             IdExBubble,
   output logic             ExMemWrite,
   output logic             ExMemBubble,
   output logic             MemWbWrite,
   output logic             McStart,
   output logic             McBusy,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int unsigned CNT_BITS = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

   typedef enum logic [1:0] {RUN, MC_BUSY, MC_LAST} state_t;

   state_t              state;
   logic [CNT_BITS-1:0] cnt;
   logic                freeze;
   logic                loadUse;
   logic                startMc;
   logic                holdEx;

   assign freeze  = ICacheStall | DCacheStall;
   assign loadUse = IdExMemRead && (IdExRegRt != '0) &&
                    ((IdExRegRt == IfIdRegRs) || (IfIdUsesRt && (IdExRegRt == IfIdRegRt)));
   assign startMc = (state == RUN) && IdExMultiCycle;
   // EX is occupied by a multi-cycle op that is not in its final cycle
   assign holdEx  = startMc || (state == MC_BUSY);

   // Combinational enables/bubbles from state and hazard inputs
   always_comb begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IfIdFlush   = 1'b0;
      IdExWrite   = 1'b0;
      IdExBubble  = 1'b0;
      ExMemWrite  = 1'b0;
      ExMemBubble = 1'b0;
      MemWbWrite  = 1'b0;
      McStart     = 1'b0;
      McBusy      = 1'b0;
      if (rst_n) begin
         McBusy = (state != RUN);
         if (!freeze) begin
            if (holdEx) begin
               // front end holds; EX result not ready, so MEM gets a nop
               ExMemWrite  = 1'b1;
               ExMemBubble = 1'b1;
               MemWbWrite  = 1'b1;
               McStart     = startMc;
            end else begin
               PcWrite    = 1'b1;
               IfIdWrite  = 1'b1;
               IdExWrite  = 1'b1;
               ExMemWrite = 1'b1;
               MemWbWrite = 1'b1;
               if (loadUse) begin
                  // branch operands are not valid under a load-use, so it waits
                  PcWrite    = 1'b0;
                  IfIdWrite  = 1'b0;
                  IdExBubble = 1'b1;
               end else if (BranchTaken) begin
                  IfIdFlush = 1'b1;
               end
            end
         end
      end
   end

   // State and latency counter; counter runs through freezes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (startMc && !freeze) begin
                  if (MC_LAT == 2) begin
                     state <= MC_LAST;
                  end else begin
                     cnt   <= CNT_BITS'(MC_LAT - 3);
                     state <= MC_BUSY;
                  end
               end
            end
            MC_BUSY: begin
               if (cnt == '0) state <= MC_LAST;
               else           cnt   <= cnt - CNT_BITS'(1);
            end
            MC_LAST: begin
               if (!freeze) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   // Performance counters: stalled-PC cycles and IF/ID flushes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!PcWrite)  stallCnt <= stallCnt + CNT_W'(1);
         if (IfIdFlush) flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   assign StallCycles = rst_n ? stallCnt : '0;
   assign FlushCount  = rst_n ? flushCnt : '0;
`else
   assign StallCycles = '0;
   assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized scoreboard bench for hazard_stall_ctrl against a cycle-age model.
module tb_hazard_stall_ctrl;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned MC_LAT = 4;
   localparam int unsigned CNT_W  = 32;

   typedef struct packed {
      logic             pcWrite;
      logic             ifIdWrite;
      logic             ifIdFlush;
      logic             idExWrite;
      logic             idExBubble;
      logic             exMemWrite;
      logic             exMemBubble;
      logic             memWbWrite;
      logic             mcStart;
      logic             mcBusy;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } outs_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             IdExMemRead = 1'b0;
   logic [REG_W-1:0] IdExRegRt = '0;
   logic [REG_W-1:0] IfIdRegRs = '0;
   logic [REG_W-1:0] IfIdRegRt = '0;
   logic             IfIdUsesRt = 1'b0;
   logic             BranchTaken = 1'b0;
   logic             IdExMultiCycle = 1'b0;
   logic             ICacheStall = 1'b0;
   logic             DCacheStall = 1'b0;
   logic             PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExBubble;
   logic             ExMemWrite, ExMemBubble, MemWbWrite, McStart, McBusy;
   logic [CNT_W-1:0] StallCycles, FlushCount;

   hazard_stall_ctrl #(.REG_W(REG_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .IdExMemRead(IdExMemRead), .IdExRegRt(IdExRegRt),
      .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdUsesRt(IfIdUsesRt),
      .BranchTaken(BranchTaken), .IdExMultiCycle(IdExMultiCycle),
      .ICacheStall(ICacheStall), .DCacheStall(DCacheStall),
      .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
      .IdExWrite(IdExWrite), .IdExBubble(IdExBubble),
      .ExMemWrite(ExMemWrite), .ExMemBubble(ExMemBubble), .MemWbWrite(MemWbWrite),
      .McStart(McStart), .McBusy(McBusy),
      .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   outs_t expQ[$];
   int    checks = 0;
   int    errors = 0;
   int    cycle  = 0;

   // Reference model: a multi-cycle op is tracked by its age in cycles since start
   bit               mActive = 1'b0;
   int               mAge    = 0;
   logic [CNT_W-1:0] mStall  = '0;
   logic [CNT_W-1:0] mFlush  = '0;

   task automatic step(input logic r, input logic lr, input int exRt, input int rs,
                       input int rt, input logic urt, input logic br, input logic mc,
                       input logic ic, input logic dc);
      outs_t e;
      bit    frz, lu, finalCyc;
      @(posedge clk);
      #1;
      rst_n = r; IdExMemRead = lr; IdExRegRt = REG_W'(exRt);
      IfIdRegRs = REG_W'(rs); IfIdRegRt = REG_W'(rt); IfIdUsesRt = urt;
      BranchTaken = br; IdExMultiCycle = mc; ICacheStall = ic; DCacheStall = dc;
      e = '0;
      if (r) begin
         frz      = ic | dc;
         lu       = lr && (exRt != 0) && ((exRt == rs) || (urt && exRt == rt));
         finalCyc = mActive && (mAge >= int'(MC_LAT) - 1);
         e.mcBusy = mActive;
`ifdef HAZ_PERF_CNT_EN
         e.stall = mStall;
         e.flush = mFlush;
`endif
         if (!frz) begin
            if ((mActive && !finalCyc) || (!mActive && mc)) begin
               e.exMemWrite = 1'b1; e.exMemBubble = 1'b1; e.memWbWrite = 1'b1;
               e.mcStart = !mActive;
            end else begin
               e.pcWrite = 1'b1; e.ifIdWrite = 1'b1; e.idExWrite = 1'b1;
               e.exMemWrite = 1'b1; e.memWbWrite = 1'b1;
               if (lu) begin
                  e.pcWrite = 1'b0; e.ifIdWrite = 1'b0; e.idExBubble = 1'b1;
               end else if (br) begin
                  e.ifIdFlush = 1'b1;
               end
            end
         end
         if (mActive) begin
            if (finalCyc && !frz) mActive = 1'b0;
            else                  mAge++;
         end else if (mc && !frz) begin
            mActive = 1'b1;
            mAge    = 1;
         end
         if (!e.pcWrite)  mStall = mStall + CNT_W'(1);
         if (e.ifIdFlush) mFlush = mFlush + CNT_W'(1);
      end else begin
         mActive = 1'b0; mAge = 0; mStall = '0; mFlush = '0;
      end
      expQ.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents a full output vector mid-cycle
   initial begin
      outs_t got, ex;
      forever begin
         @(negedge clk);
         cycle++;
         if (expQ.size() > 0) begin
            ex  = expQ.pop_front();
            got = {PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExBubble, ExMemWrite,
                   ExMemBubble, MemWbWrite, McStart, McBusy, StallCycles, FlushCount};
            checks++;
            if (got !== ex) begin
               errors++;
               $display("FAIL outputs cycle %0d: got %h expected %h", cycle, got, ex);
            end
         end
      end
   end

   initial begin
      // reset
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use then release
      step(1, 1, 8, 8, 0, 0, 0, 0, 0, 0);
      step(1, 0, 8, 8, 0, 0, 0, 0, 0, 0);
      // no stall: rt=0 destination, rt match without rt use
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 8, 3, 8, 0, 0, 0, 0, 0);
      step(1, 1, 8, 3, 8, 1, 0, 0, 0, 0);
      // multi-cycle op with IdExMultiCycle held
      repeat (6) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // multi-cycle op with data-cache freeze in cycles 2-6
      for (int c = 0; c < 9; c++)
         step(1, 0, 0, 0, 0, 0, 0, (c < 8), 0, (c >= 2 && c <= 6));
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // freeze defers a multi-cycle start
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // branch with load-use, branch alone
      step(1, 1, 8, 8, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset asserted during MC_BUSY
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(99) >= 2),
              ($urandom_range(2) == 0), int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(3)), $urandom_range(1) == 1, ($urandom_range(3) == 0),
              ($urandom_range(7) == 0), ($urandom_range(9) == 0), ($urandom_range(9) == 0));
      end
      @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
